// File: rtl/led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_ctrl
// Purpose  : Debounced button front end driving NUM_LED LEDs in one of four
//            pattern modes (OFF / STATIC / BLINK / CHASE) with a
//            button-selectable step rate.
// Options  : LED_PATTERN_PWM_DIM_EN adds a 4-bit brightness output and a
//            16-step PWM dimmer; btn4 then steps brightness instead of pause.
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_ctrl #(
  parameter int NUM_BTN         = 5,
  parameter int NUM_LED         = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BASE_SHIFT      = 20,
  parameter int SPEED_RESET     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn,
  output logic [NUM_LED-1:0] led,
  output logic [1:0]         mode,
  output logic [2:0]         speed,
`ifdef LED_PATTERN_PWM_DIM_EN
  output logic [3:0]         brightness,
`endif
  output logic [NUM_BTN-1:0] btn_pulse
);

  localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PRE_W    = BASE_SHIFT + 8;
  localparam int STATIC_W = (NUM_BTN < NUM_LED) ? NUM_BTN : NUM_LED;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_STATIC = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_CHASE  = 2'd3
  } mode_t;

  // ---------------------------------------------------------------- inputs
  logic [NUM_BTN-1:0] r_sync1, r_sync2, r_level, w_level_next, r_pulse;

  generate
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      logic [CNT_W-1:0] r_cnt;
      logic             w_accept;

      // The synced value must keep disagreeing with the level through a full
      // DEBOUNCE_CYCLES count before the level follows it.
      assign w_accept = (r_sync2[i] != r_level[i]) && (r_cnt == CNT_W'(DEBOUNCE_CYCLES));
      assign w_level_next[i] = w_accept ? r_sync2[i] : r_level[i];

      // Per-button stability counter, cleared whenever input matches level.
      always_ff @(posedge clk) begin
        if (!rst_n)                          r_cnt <= '0;
        else if (r_sync2[i] == r_level[i])   r_cnt <= '0;
        else if (w_accept)                   r_cnt <= '0;
        else                                 r_cnt <= r_cnt + 1'b1;
      end
    end
  endgenerate

  // Two-flop synchroniser, debounced level and rising-edge pulse register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_level <= '0;
      r_pulse <= '0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      r_level <= w_level_next;
      r_pulse <= w_level_next & ~r_level;
    end
  end

  // ---------------------------------------------------------------- control
  mode_t              r_mode, w_mode_next;
  logic [1:0]         w_mode_inc;
  logic [2:0]         r_speed, w_speed_next;
  logic               r_dir, w_dir_next;
  logic               r_paused, w_paused_next;
  logic               r_blink, w_blink_next;
  logic [NUM_LED-1:0] r_chase, w_chase_next;
  logic [PRE_W-1:0]   r_pre, w_pre_next, w_mask;
  logic               w_step;
  logic [NUM_LED-1:0] w_pattern, r_led;
`ifdef LED_PATTERN_PWM_DIM_EN
  logic [3:0]         r_bright, w_bright_next, r_pwm;
`endif

  // Step fires when the low BASE_SHIFT+speed prescaler bits are all ones.
  assign w_mask     = {PRE_W{1'b1}} >> (4'd8 - {1'b0, r_speed});
  assign w_step     = ((r_pre & w_mask) == w_mask) && !r_paused;
  assign w_mode_inc = r_mode + 2'd1;

  // State register for mode and all pattern state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode   <= MODE_BLINK;
      r_speed  <= 3'(SPEED_RESET);
      r_dir    <= 1'b0;
      r_paused <= 1'b0;
      r_blink  <= 1'b0;
      r_chase  <= {{(NUM_LED-1){1'b0}}, 1'b1};
      r_pre    <= '0;
    end else begin
      r_mode   <= w_mode_next;
      r_speed  <= w_speed_next;
      r_dir    <= w_dir_next;
      r_paused <= w_paused_next;
      r_blink  <= w_blink_next;
      r_chase  <= w_chase_next;
      r_pre    <= w_pre_next;
    end
  end

  // Next-state logic: button actions, then mode change or pattern step.
  always_comb begin
    w_mode_next   = r_mode;
    w_speed_next  = r_speed;
    w_dir_next    = r_dir;
    w_paused_next = r_paused;
    w_blink_next  = r_blink;
    w_chase_next  = r_chase;
    w_pre_next    = r_pre + 1'b1;
`ifdef LED_PATTERN_PWM_DIM_EN
    w_bright_next = r_bright;
`endif
    if (r_pulse[1] && !r_pulse[2] && (r_speed != 3'd0)) w_speed_next = r_speed - 3'd1;
    if (r_pulse[2] && !r_pulse[1] && (r_speed != 3'd7)) w_speed_next = r_speed + 3'd1;
    if (r_pulse[3]) w_dir_next = ~r_dir;
`ifdef LED_PATTERN_PWM_DIM_EN
    if (r_pulse[4]) w_bright_next = r_bright + 4'd1;
`else
    if (r_pulse[4]) w_paused_next = ~r_paused;
`endif
    // A mode change restarts the pattern and swallows a coincident step.
    if (r_pulse[0]) begin
      w_mode_next  = mode_t'(w_mode_inc);
      w_pre_next   = '0;
      w_blink_next = 1'b0;
      w_chase_next = {{(NUM_LED-1){1'b0}}, 1'b1};
    end else if (w_step) begin
      w_blink_next = ~r_blink;
      w_chase_next = r_dir ? {r_chase[0], r_chase[NUM_LED-1:1]}
                           : {r_chase[NUM_LED-2:0], r_chase[NUM_LED-1]};
    end
  end

  // Pattern selected by the current mode.
  always_comb begin
    w_pattern = '0;
    case (r_mode)
      MODE_STATIC: w_pattern[STATIC_W-1:0] = r_level[STATIC_W-1:0];
      MODE_BLINK:  w_pattern = {NUM_LED{r_blink}};
      MODE_CHASE:  w_pattern = r_chase;
      default:     w_pattern = '0;
    endcase
  end

`ifdef LED_PATTERN_PWM_DIM_EN
  // Brightness, PWM phase counter and dimmed LED register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bright <= 4'd15;
      r_pwm    <= 4'd0;
      r_led    <= '0;
    end else begin
      r_bright <= w_bright_next;
      r_pwm    <= r_pwm + 4'd1;
      r_led    <= w_pattern & {NUM_LED{r_pwm <= r_bright}};
    end
  end

  assign brightness = r_bright;
`else
  // Registered LED drive.
  always_ff @(posedge clk) begin
    if (!rst_n) r_led <= '0;
    else        r_led <= w_pattern;
  end
`endif

  assign led       = r_led;
  assign mode      = r_mode;
  assign speed     = r_speed;
  assign btn_pulse = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_ctrl
// Purpose  : Self-checking bench for led_pattern_ctrl (small parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pattern_ctrl;

  localparam int NB = 5;
  localparam int NL = 8;
  localparam int DC = 4;
  localparam int BS = 2;
  localparam int SR = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] btn = '0;
  logic [NL-1:0] led;
  logic [1:0]    mode;
  logic [2:0]    speed;
  logic [NB-1:0] btn_pulse;
`ifdef LED_PATTERN_PWM_DIM_EN
  logic [3:0]    brightness;
`endif

  led_pattern_ctrl #(
    .NUM_BTN(NB), .NUM_LED(NL), .DEBOUNCE_CYCLES(DC),
    .BASE_SHIFT(BS), .SPEED_RESET(SR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .led(led), .mode(mode),
    .speed(speed),
`ifdef LED_PATTERN_PWM_DIM_EN
    .brightness(brightness),
`endif
    .btn_pulse(btn_pulse)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [NB-1:0] press;
    logic [1:0]    exp_mode;
    logic [2:0]    exp_speed;
    int            period;   // expected blink step period after press, 0 = skip
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Hold a button mask for 10 cycles, release for 10, expect one pulse per pressed bit.
  task automatic press(input logic [NB-1:0] m);
    int pc[NB];
    logic [31:0] a, e;
    for (int b = 0; b < NB; b++) pc[b] = 0;
    btn = m;
    for (int k = 0; k < 20; k++) begin
      if (k == 10) btn = '0;
      tick();
      for (int b = 0; b < NB; b++) if (btn_pulse[b]) pc[b]++;
    end
    a = '0;
    e = '0;
    for (int b = 0; b < NB; b++) begin
      a |= 32'(pc[b] & 15) << (4 * b);
      e |= 32'(m[b]) << (4 * b);
    end
    check("pulse_count", a, e);
  endtask

  task automatic wait_led(input logic [NL-1:0] v, input int bound, input string name);
    int n = 0;
    while (led !== v && n < bound) begin
      tick();
      n++;
    end
    check(name, 32'(led), 32'(v));
  endtask

  task automatic wait_change(input int bound);
    logic [NL-1:0] prev = led;
    int n = 0;
    while (led === prev && n < bound) begin
      tick();
      n++;
    end
  endtask

  // Cycles between two consecutive LED changes in BLINK mode.
  task automatic measure_period(input int exp);
    logic [NL-1:0] prev;
    int cyc = 0;
    wait_change(2000);
    prev = led;
    while (led === prev && cyc < 2000) begin
      tick();
      cyc++;
    end
    check("step_period", cyc, exp);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m_mode, m_speed;
    logic [NB-1:0] m;
    logic [NL-1:0] frozen;
    int changes, pcount;

    // ------------------------------------------------ reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_mode", 32'(mode), 32'd2);
    check("rst_speed", 32'(speed), 32'(SR));
    check("rst_led", 32'(led), 32'd0);
    check("rst_pulse", 32'(btn_pulse), 32'd0);
    rst_n = 1'b1;
    tick();

    // ------------------------------------------------ debounce
    pcount = 0;
    btn = 5'b00001;
    for (int k = 0; k < 13; k++) begin
      if (k == 3) btn = '0;
      tick();
      if (btn_pulse[0]) pcount++;
    end
    check("glitch_pulses", pcount, 0);
    check("glitch_mode", 32'(mode), 32'd2);
    btn = 5'b00001;
    for (int k = 0; k < 13; k++) begin
      if (k == 10) btn = '0;
      tick();
      check("db_pulse_edge", 32'(btn_pulse[0]), 32'(k == 6));
      if (k == 7) check("db_mode_after", 32'(mode), 32'd3);
    end

    // ------------------------------------------------ table: modes and speeds
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) tbl.push_back('{5'b00001, 2'((3 + i) % 4), 3'd4, (i == 3) ? 64 : 0});
    for (int i = 0; i < 6; i++) tbl.push_back('{5'b00010, 2'd2, 3'((i < 3) ? 3 - i : 0), (i == 5) ? 4 : 0});
    for (int i = 0; i < 9; i++) tbl.push_back('{5'b00100, 2'd2, 3'((i < 7) ? i + 1 : 7), (i == 8) ? 512 : 0});
    tbl.push_back('{5'b00110, 2'd2, 3'd7, 0});
    for (int i = 0; i < 3; i++) tbl.push_back('{5'b00001, 2'((3 + i) % 4), 3'd7, 0});
    foreach (tbl[i]) begin
      press(tbl[i].press);
      check("tbl_mode", 32'(mode), 32'(tbl[i].exp_mode));
      check("tbl_speed", 32'(speed), 32'(tbl[i].exp_speed));
      if (tbl[i].period != 0) measure_period(tbl[i].period);
    end

    // ------------------------------------------------ STATIC follows debounced buttons
    btn = 5'b00110;
    repeat (12) tick();
    check("static_led", 32'(led), 32'h06);
    check("static_speed", 32'(speed), 32'd7);
    btn = '0;
    repeat (12) tick();
    check("static_release", 32'(led), 32'h00);

    // ------------------------------------------------ CHASE
    press(5'b00001);
    press(5'b00001);
    check("chase_mode", 32'(mode), 32'd3);
    for (int i = 0; i < 7; i++) press(5'b00010);
    check("chase_speed", 32'(speed), 32'd0);
    wait_led(8'h01, 200, "chase_start");
    for (int i = 1; i <= 8; i++) begin
      wait_change(64);
      check("chase_up", 32'(led), 32'(1) << (i % 8));
    end
    press(5'b01000);
    wait_led(8'h01, 200, "chase_dn_start");
    wait_change(64);
    check("chase_down_wrap", 32'(led), 32'h80);
    press(5'b10000);
    frozen = led;
    changes = 0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (led !== frozen) changes++;
    end
    check("pause_frozen", changes, 0);
    press(5'b10000);

    // ------------------------------------------------ reset mid-chase with press in flight
    wait_led(8'h10, 200, "chase_0x10");
    btn = 5'b00001;
    repeat (3) tick();
    rst_n = 1'b0;
    btn = '0;
    tick();
    check("midrst_mode", 32'(mode), 32'd2);
    check("midrst_speed", 32'(speed), 32'd4);
    check("midrst_led", 32'(led), 32'd0);
    check("midrst_pulse", 32'(btn_pulse), 32'd0);
    rst_n = 1'b1;
    pcount = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (btn_pulse != '0) pcount++;
    end
    check("midrst_no_pulse", pcount, 0);

    // ------------------------------------------------ random presses vs model
    m_mode = 2;
    m_speed = SR;
    for (int it = 0; it < 25; it++) begin
      m = NB'($urandom_range(1, 31));
      press(m);
      if (m[0]) m_mode = (m_mode + 1) % 4;
      if (m[1] && !m[2]) m_speed = (m_speed > 0) ? m_speed - 1 : 0;
      if (m[2] && !m[1]) m_speed = (m_speed < 7) ? m_speed + 1 : 7;
      check("rand_mode", 32'(mode), 32'(m_mode));
      check("rand_speed", 32'(speed), 32'(m_speed));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
